// File: rtl/trace_replay_pkg.sv
// Shared types for the trace replay block: controller states, record layout and
// the saturating timestamp-counter helper.
package trace_replay_pkg;

   localparam int unsigned TS_WIDTH      = 32;
   localparam int unsigned PAYLOAD_WIDTH = 32;

   typedef enum logic [1:0] {
      StLoad,
      StReplay,
      StDone
   } state_e;

   typedef struct packed {
      logic [TS_WIDTH-1:0]      timestamp;
      logic [PAYLOAD_WIDTH-1:0] payload;
   } record_t;

   // Relative replay time sticks at its maximum instead of wrapping.
   function automatic logic [TS_WIDTH-1:0] sat_inc(input logic [TS_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/trace_replay_if.sv
// Load bus and start/clear handshakes of the trace replay block.
// master drives strobes and beat data, slave returns the ready signals.
interface trace_replay_if #(
   parameter int unsigned owidth = 32
) ();

   logic              in_enq__ENA;
   logic [owidth-1:0] in_enq_v;
   logic              in_enq_last;
   logic              in_enq__RDY;
   logic              start__ENA;
   logic              start__RDY;
   logic              clear__ENA;
   logic              clear__RDY;

   modport master (
      output in_enq__ENA, in_enq_v, in_enq_last, start__ENA, clear__ENA,
      input  in_enq__RDY, start__RDY, clear__RDY
   );

   modport slave (
      input  in_enq__ENA, in_enq_v, in_enq_last, start__ENA, clear__ENA,
      output in_enq__RDY, start__RDY, clear__RDY
   );

endinterface

// File: rtl/trace_replay_bram.sv
// Simple dual-port record store: one write port, one read port with a
// registered output that holds its value until the next read.
module trace_replay_bram #(
   parameter int unsigned width = 64,
   parameter int unsigned depth = 1024
) (
   input  logic                     CLK,
   input  logic                     write__ENA,
   input  logic [$clog2(depth)-1:0] write_addr,
   input  logic [width-1:0]         write_data,
   input  logic                     read__ENA,
   input  logic [$clog2(depth)-1:0] read_addr,
   output logic [width-1:0]         dataOut
);

   logic [width-1:0] mem [depth];
   logic [width-1:0] dout_q;

   // Write port and one-cycle-latency read port; contents are not reset.
   always_ff @(posedge CLK) begin
      if (write__ENA) begin
         mem[write_addr] <= write_data;
      end
      if (read__ENA) begin
         dout_q <= mem[read_addr];
      end
   end

   assign dataOut = dout_q;

endmodule

// File: rtl/trace_replay.sv
// Trace replay: records {timestamp, payload} are loaded as two bus beats, then
// replayed so each payload pulses out once the relative cycle counter reaches
// its timestamp. Define TRACE_REPLAY_LOOP_EN to replay the buffer endlessly
// until cleared; by default replay is single-shot.
module trace_replay
   import trace_replay_pkg::*;
#(
   parameter int unsigned width  = 64,
   parameter int unsigned owidth = 32,
   parameter int unsigned depth  = 1024
) (
   input  logic                      CLK,
   input  logic                      nRST,
   trace_replay_if.slave             bus,
   output logic                      enable,
   output logic [width-TS_WIDTH-1:0] data,
   output logic                      busy,
   output logic [$clog2(depth):0]    count,
   output logic                      late,
   output logic                      proto_err
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = width - TS_WIDTH;

   state_e              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       rd_idx_q, rd_idx_d;
   logic                beat_q, beat_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [TS_WIDTH-1:0] cnt_q, cnt_d;
   logic                rec_vld_q, rec_vld_d;
   logic                late_q, late_d;
   logic                perr_q, perr_d;
   logic [PW-1:0]       data_q, data_d;

   logic                wr_en, rd_en;
   logic [AW-1:0]       rd_addr;
   record_t             wr_rec, rd_rec;
   logic [width-1:0]    rd_data;
   logic [owidth-1:0]   beat_v;
   logic                enq_rdy, start_rdy, clear_rdy;
   logic                enq_fire, start_fire, clear_fire, emit;

   assign beat_v = bus.in_enq_v;
   assign rd_rec = rd_data;

   // Handshake readiness and the single-cycle emit decision.
   always_comb begin
      enq_rdy   = (state_q == StLoad) && (count_q < CW'(depth));
      start_rdy = (state_q == StLoad) && (count_q != '0);
`ifdef TRACE_REPLAY_LOOP_EN
      clear_rdy = 1'b1;
`else
      clear_rdy = (state_q == StLoad) || (state_q == StDone);
`endif
      clear_fire = bus.clear__ENA && clear_rdy;
      // clear wins over any beat or start in the same cycle
      enq_fire   = bus.in_enq__ENA && enq_rdy && !clear_fire;
      start_fire = bus.start__ENA && start_rdy && !clear_fire;
      emit       = (state_q == StReplay) && rec_vld_q && (cnt_q >= rd_rec.timestamp) &&
                   !clear_fire;
   end

   // Next state: beat assembler, replay sequencing and clear.
   always_comb begin
      state_d          = state_q;
      count_d          = count_q;
      rd_idx_d         = rd_idx_q;
      beat_d           = beat_q;
      ts_d             = ts_q;
      cnt_d            = cnt_q;
      rec_vld_d        = rec_vld_q;
      late_d           = late_q;
      perr_d           = perr_q;
      data_d           = data_q;
      wr_en            = 1'b0;
      rd_en            = 1'b0;
      rd_addr          = '0;
      wr_rec.timestamp = ts_q;
      wr_rec.payload   = beat_v;

      if (enq_fire) begin
         if (!beat_q) begin
            if (bus.in_enq_last) begin
               perr_d = 1'b1;
            end else begin
               ts_d   = beat_v[TS_WIDTH-1:0];
               beat_d = 1'b1;
            end
         end else begin
            beat_d = 1'b0;
            if (!bus.in_enq_last) begin
               perr_d = 1'b1;
            end else begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
            end
         end
      end

      if (start_fire) begin
         state_d   = StReplay;
         cnt_d     = '0;
         rd_en     = 1'b1;
         rd_idx_d  = CW'(1);
         rec_vld_d = 1'b1;
      end

      if (state_q == StReplay) begin
         cnt_d = sat_inc(cnt_q);
         if (emit) begin
            data_d = rd_rec.payload;
            if (cnt_q > rd_rec.timestamp) begin
               late_d = 1'b1;
            end
            // The output register holds the current record, so the next read
            // is only issued once it has been consumed.
            if (rd_idx_q < count_q) begin
               rd_en    = 1'b1;
               rd_addr  = rd_idx_q[AW-1:0];
               rd_idx_d = rd_idx_q + 1'b1;
            end else begin
`ifdef TRACE_REPLAY_LOOP_EN
               rd_en    = 1'b1;
               rd_idx_d = CW'(1);
               cnt_d    = '0;
`else
               state_d   = StDone;
               rec_vld_d = 1'b0;
`endif
            end
         end
      end

      if (clear_fire) begin
         state_d   = StLoad;
         count_d   = '0;
         late_d    = 1'b0;
         perr_d    = 1'b0;
         beat_d    = 1'b0;
         rec_vld_d = 1'b0;
         cnt_d     = '0;
      end
   end

   // State registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= StLoad;
         count_q   <= '0;
         rd_idx_q  <= '0;
         beat_q    <= 1'b0;
         ts_q      <= '0;
         cnt_q     <= '0;
         rec_vld_q <= 1'b0;
         late_q    <= 1'b0;
         perr_q    <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rd_idx_q  <= rd_idx_d;
         beat_q    <= beat_d;
         ts_q      <= ts_d;
         cnt_q     <= cnt_d;
         rec_vld_q <= rec_vld_d;
         late_q    <= late_d;
         perr_q    <= perr_d;
         data_q    <= data_d;
      end
   end

   trace_replay_bram #(
      .width (width),
      .depth (depth)
   ) u_bram (
      .CLK        (CLK),
      .write__ENA (wr_en),
      .write_addr (count_q[AW-1:0]),
      .write_data (wr_rec),
      .read__ENA  (rd_en),
      .read_addr  (rd_addr),
      .dataOut    (rd_data)
   );

   assign bus.in_enq__RDY = enq_rdy;
   assign bus.start__RDY  = start_rdy;
   assign bus.clear__RDY  = clear_rdy;
   assign enable          = emit;
   assign data            = emit ? rd_rec.payload : data_q;
   assign busy            = (state_q == StReplay);
   assign count           = count_q;
   assign late            = late_q;
   assign proto_err       = perr_q;

endmodule

// File: tb/tb_trace_replay.sv
// Bench for trace_replay: directed load/replay scenarios feed a scoreboard of
// expected {payload, cycle} pulses; a negedge monitor checks every enable.
module tb_trace_replay;

   localparam int unsigned Depth = 4;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        enable;
   logic [31:0] data;
   logic        busy;
   logic [2:0]  count;
   logic        late;
   logic        proto_err;

   always #5 CLK = ~CLK;

   trace_replay_if #(.owidth(32)) bus ();

   trace_replay #(
      .width  (64),
      .owidth (32),
      .depth  (Depth)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .bus       (bus),
      .enable    (enable),
      .data      (data),
      .busy      (busy),
      .count     (count),
      .late      (late),
      .proto_err (proto_err)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: every enable pulse must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (enable) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_enable: got data %0h at cycle %0d, want no pulse",
                     data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (data !== mon_e.data || cyc != mon_e.cyc) begin
               miscompares++;
               $display("FAIL emit: got data %0h at cycle %0d, want %0h at cycle %0d",
                        data, cyc, mon_e.data, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic put_beat(input logic [31:0] v, input logic last, output logic acc);
      bus.in_enq__ENA = 1'b1;
      bus.in_enq_v    = v;
      bus.in_enq_last = last;
      acc = bus.in_enq__RDY;
      step();
      bus.in_enq__ENA = 1'b0;
   endtask

   task automatic put_record(input logic [31:0] ts, input logic [31:0] p);
      logic a;
      put_beat(ts, 1'b0, a);
      put_beat(p, 1'b1, a);
   endtask

   task automatic do_start(output int unsigned s);
      check("start_rdy", bus.start__RDY, 1);
      bus.start__ENA = 1'b1;
      s = cyc;
      step();
      bus.start__ENA = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear__ENA = 1'b1;
      step();
      bus.clear__ENA = 1'b0;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) step();
   endtask

   task automatic push(input logic [31:0] d, input int unsigned c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   int unsigned s;
   logic        acc;
   logic        loop_en;

   initial begin
`ifdef TRACE_REPLAY_LOOP_EN
      loop_en = 1'b1;
`else
      loop_en = 1'b0;
`endif
      bus.in_enq__ENA = 1'b0;
      bus.in_enq_v    = '0;
      bus.in_enq_last = 1'b0;
      bus.start__ENA  = 1'b0;
      bus.clear__ENA  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Reset state
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_enable", enable, 0);
      check("rst_data", data, 0);
      check("rst_late", late, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_enq_rdy", bus.in_enq__RDY, 1);
      check("rst_start_rdy", bus.start__RDY, 0);
      check("rst_clear_rdy", bus.clear__RDY, 1);

      // Two on-time records: pulses at T+5 and T+9, T = start cycle + 1
      put_record(32'd5, 32'hA);
      put_record(32'd9, 32'hB);
      check("s1_count", count, 2);
      do_start(s);
      push(32'hA, s + 6);
      push(32'hB, s + 10);
      check("s1_busy", busy, 1);
      check("s1_clear_rdy_replay", bus.clear__RDY, loop_en);
      wait_until(s + 11);
      check("s1_busy_after", busy, loop_en);
      check("s1_start_rdy_after", bus.start__RDY, 0);
      check("s1_late", late, 0);
      check("s1_data_hold", data, 32'hB);
      do_clear();
      check("s1_clear_count", count, 0);

      // Equal timestamps: back-to-back pulses, second is late
      put_record(32'd0, 32'h11);
      put_record(32'd0, 32'h22);
      do_start(s);
      push(32'h11, s + 1);
      push(32'h22, s + 2);
      wait_until(s + 3);
      check("s2_late", late, 1);
      do_clear();
      check("s2_late_cleared", late, 0);

      // Framing errors
      put_beat(32'd5, 1'b1, acc);
      check("s3_acc", acc, 1);
      check("s3_proto_err", proto_err, 1);
      check("s3_count0", count, 0);
      put_record(32'd3, 32'h33);
      check("s3_count1", count, 1);
      put_beat(32'd1, 1'b0, acc);
      put_beat(32'd2, 1'b0, acc);
      check("s3_count_after_bad_beat1", count, 1);
      check("s3_proto_err_sticky", proto_err, 1);
      do_clear();
      check("s3_proto_err_cleared", proto_err, 0);
      check("s3_count_cleared", count, 0);

      // Clear and beat together: beat is dropped, so the next last=1 beat is beat 0
      bus.in_enq__ENA = 1'b1;
      bus.in_enq_v    = 32'd7;
      bus.in_enq_last = 1'b0;
      bus.clear__ENA  = 1'b1;
      step();
      bus.in_enq__ENA = 1'b0;
      bus.clear__ENA  = 1'b0;
      put_beat(32'd8, 1'b1, acc);
      check("s4_clear_wins_perr", proto_err, 1);
      check("s4_clear_wins_count", count, 0);
      do_clear();

      // Full buffer, then reset mid-replay
      put_record(32'd10, 32'h1);
      put_record(32'd20, 32'h2);
      put_record(32'd30, 32'h3);
      put_record(32'd40, 32'h4);
      check("s5_full_rdy", bus.in_enq__RDY, 0);
      check("s5_full_count", count, 4);
      put_beat(32'd50, 1'b0, acc);
      check("s5_beat0_rejected", acc, 0);
      put_beat(32'h55, 1'b1, acc);
      check("s5_beat1_rejected", acc, 0);
      check("s5_count_still_full", count, 4);
      check("s5_no_perr", proto_err, 0);
      do_start(s);
      push(32'h1, s + 11);
      wait_until(s + 15);
      nRST = 1'b0;
      #1;
      check("s5_rst_enable", enable, 0);
      check("s5_rst_busy", busy, 0);
      check("s5_rst_count", count, 0);
      check("s5_rst_data", data, 0);
      step();
      step();
      nRST = 1'b1;
      check("s5_load_enq_rdy", bus.in_enq__RDY, 1);
      check("s5_load_start_rdy", bus.start__RDY, 0);
      repeat (40) step();

      // Single record ts=2: period 3 when looping, one pulse otherwise
      put_record(32'd2, 32'h77);
      do_start(s);
      push(32'h77, s + 3);
      if (loop_en) begin
         push(32'h77, s + 6);
         push(32'h77, s + 9);
         push(32'h77, s + 12);
      end
      check("s6_clear_rdy_replay", bus.clear__RDY, loop_en);
      wait_until(s + 13);
      check("s6_busy_before_clear", busy, loop_en);
      do_clear();
      check("s6_busy_after_clear", busy, 0);
      check("s6_count_after_clear", count, 0);
      repeat (10) step();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
